// File: rtl/dbus_uncached_bridge.sv
// Uncached data-bus bridge: turns one CPU dbus request into a single-beat
// cbus transaction and hands the result back as a dbus response. Holds one
// outstanding transaction, with an optional watchdog and a misalignment flag.

package dbus_uncached_bridge_pkg;

    typedef logic [2:0] msize_t;
    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;
    localparam msize_t MSIZE8 = 3'd3;

    typedef logic [7:0] mlen_t;
    localparam mlen_t MLEN1 = 8'd0;

    typedef logic [1:0] axi_burst_t;
    localparam axi_burst_t AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

module dbus_uncached_bridge
    import dbus_uncached_bridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 0,
    parameter logic [63:0] TIMEOUT_DATA   = 64'hDEAD_BEEF_DEAD_BEEF,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp,
    output logic       err_misaligned,
    output logic       err_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WATCHDOG_ON = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    logic [63:0]      req_addr;
    msize_t           req_size;
    logic [7:0]       req_strobe;
    logic [63:0]      req_data;
    logic [63:0]      rdata;
    logic [CNT_W-1:0] wait_cnt;

    // Natural alignment of the low address bits against the access size.
    function automatic logic is_misaligned(input msize_t size, input logic [2:0] lo);
        case (size)
            MSIZE2:  return lo[0];
            MSIZE4:  return |lo[1:0];
            MSIZE8:  return |lo;
            default: return 1'b0;
        endcase
    endfunction

    // Transaction FSM: accept in IDLE, wait for the last beat in BUSY, answer in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            req_addr       <= '0;
            req_size       <= '0;
            req_strobe     <= '0;
            req_data       <= '0;
            rdata          <= '0;
            wait_cnt       <= '0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dreq.valid) begin
                        req_addr   <= dreq.addr;
                        req_size   <= dreq.size;
                        req_strobe <= dreq.strobe;
                        req_data   <= dreq.data;
                        wait_cnt   <= '0;
                        state      <= S_BUSY;
                        if (ALIGN_CHECK && is_misaligned(dreq.size, dreq.addr[2:0])) begin
                            err_misaligned <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    // Any accepted beat refreshes the data register; only the
                    // last beat ends the transaction.
                    if (cresp.ready) begin
                        rdata <= cresp.data;
                    end
                    if (cresp.ready && cresp.last) begin
                        state <= S_DONE;
                    end else if (WATCHDOG_ON && (wait_cnt == CNT_LAST)) begin
                        rdata       <= TIMEOUT_DATA;
                        err_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Response side: addr_ok is a same-cycle acknowledge, data_ok follows the DONE state.
    always_comb begin
        dresp         = '0;
        dresp.addr_ok = (state == S_IDLE) && dreq.valid;
        dresp.data_ok = (state == S_DONE);
        dresp.data    = (state == S_DONE) ? rdata : 64'd0;
    end

    // Request side: the latched fields are forwarded unmodified while BUSY.
    always_comb begin
        creq          = '0;
        creq.valid    = (state == S_BUSY);
        creq.is_write = (req_strobe != 8'd0);
        creq.size     = req_size;
        creq.addr     = req_addr;
        creq.strobe   = req_strobe;
        creq.data     = req_data;
        creq.len      = MLEN1;
        creq.burst    = AXI_BURST_INCR;
    end

endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// Directed bench for dbus_uncached_bridge: a vector table of single
// transactions plus hand-written hold-off, watchdog and reset sequences.

module tb_dbus_uncached_bridge;
    import dbus_uncached_bridge_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    logic       err_misaligned;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dbus_uncached_bridge #(
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_DATA  (64'hDEAD_BEEF_DEAD_BEEF),
        .ALIGN_CHECK   (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dreq          (dreq),
        .dresp         (dresp),
        .creq          (creq),
        .cresp         (cresp),
        .err_misaligned(err_misaligned),
        .err_timeout   (err_timeout)
    );

    typedef struct {
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        int          stall;
        bit          junk;
        logic [63:0] rdata;
        bit          exp_write;
        bit          exp_mis;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dreq  = '0;
        cresp = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_dresp", dresp, '0);
        check("rst_creq_valid", creq.valid, 1'b0);
        check("rst_err_mis", err_misaligned, 1'b0);
        check("rst_err_to", err_timeout, 1'b0);
    endtask

    task automatic run_txn(input vec_t v);
        dreq.valid  = 1'b1;
        dreq.addr   = v.addr;
        dreq.size   = v.size;
        dreq.strobe = v.strobe;
        dreq.data   = v.wdata;
        cresp       = '0;
        #1;
        check("accept_addr_ok", dresp.addr_ok, 1'b1);
        check("accept_mis_not_yet", err_misaligned, 1'b0);
        @(negedge clk);
        dreq.valid = 1'b0;
        dreq.data  = ~v.wdata;
        #1;
        check("creq_valid", creq.valid, 1'b1);
        check("creq_is_write", creq.is_write, v.exp_write);
        check("creq_addr", creq.addr, v.addr);
        check("creq_size", creq.size, v.size);
        check("creq_strobe", creq.strobe, v.strobe);
        check("creq_data", creq.data, v.wdata);
        check("creq_len", creq.len, MLEN1);
        check("creq_burst", creq.burst, AXI_BURST_INCR);
        check("busy_addr_ok", dresp.addr_ok, 1'b0);
        check("err_misaligned", err_misaligned, v.exp_mis);
        for (int c = 0; c < v.stall; c++) begin
            cresp.ready = v.junk;
            cresp.last  = 1'b0;
            cresp.data  = 64'h0BAD_0BAD_0BAD_0BAD;
            #1;
            check("stall_valid", creq.valid, 1'b1);
            check("stall_no_data_ok", dresp.data_ok, 1'b0);
            @(negedge clk);
        end
        cresp.ready = 1'b1;
        cresp.last  = 1'b1;
        cresp.data  = v.rdata;
        @(negedge clk);
        cresp = '0;
        #1;
        check("done_data_ok", dresp.data_ok, 1'b1);
        check("done_data", dresp.data, v.rdata);
        check("done_creq_valid", creq.valid, 1'b0);
        @(negedge clk);
        #1;
        check("after_data_ok", dresp.data_ok, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] exp_aok;
        int         accepts;
        int         hs;
        int         dok;
        int         first_acc;
        int         second_acc;

        vecs[0] = '{64'h0000_0000_8000_0010, MSIZE8, 8'h00, 64'h0, 3, 1'b0, 64'h1122_3344_5566_7788, 1'b0, 1'b0};
        vecs[1] = '{64'h0000_0000_1000_0004, MSIZE4, 8'hF0, 64'hCAFE_BABE_0000_0000, 0, 1'b0, 64'h5555_AAAA_5555_AAAA, 1'b1, 1'b0};
        vecs[2] = '{64'h0000_0000_8000_0003, MSIZE4, 8'h00, 64'h0, 1, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b1};
        vecs[3] = '{64'h0000_0000_4000_0001, MSIZE2, 8'h03, 64'h0000_0000_0000_BEEF, 2, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[4] = '{64'h0000_0000_4000_0002, MSIZE2, 8'h00, 64'h0, 2, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0};
        vecs[5] = '{64'h0000_0000_4000_0004, MSIZE8, 8'h00, 64'h0, 0, 1'b0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1};
        vecs[6] = '{64'h0000_0000_4000_0007, MSIZE1, 8'h80, 64'h5A00_0000_0000_0000, 1, 1'b0, 64'h1, 1'b1, 1'b0};

        reset = 1'b1;
        dreq  = '0;
        cresp = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("init_dresp", dresp, '0);
        check("init_creq_valid", creq.valid, 1'b0);
        check("init_err_mis", err_misaligned, 1'b0);
        check("init_err_to", err_timeout, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i]);
            do_reset();
        end

        // Hold-off: dreq.valid stays high; accepts land on cycles 0 and 3.
        exp_aok    = 6'b001001;
        accepts    = 0;
        hs         = 0;
        dok        = 0;
        first_acc  = -1;
        second_acc = -1;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_3000_0008;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hD1D1_D1D1_D1D1_D1D1;
        cresp.ready = 1'b1;
        cresp.last  = 1'b1;
        cresp.data  = 64'h77;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            check("hold_addr_ok", dresp.addr_ok, exp_aok[cyc]);
            if (dresp.addr_ok) begin
                if (accepts == 0) first_acc = cyc;
                else second_acc = cyc;
                accepts++;
            end
            if (creq.valid && cresp.ready && cresp.last) hs++;
            if (dresp.data_ok) dok++;
            if (cyc == 1) begin
                check("hold_creq_data1", creq.data, 64'hD1D1_D1D1_D1D1_D1D1);
                dreq.data = 64'hD2D2_D2D2_D2D2_D2D2;
            end
            if (cyc == 4) check("hold_creq_data2", creq.data, 64'hD2D2_D2D2_D2D2_D2D2);
            if (cyc == 5) begin
                dreq.valid = 1'b0;
                cresp      = '0;
            end
            @(negedge clk);
        end
        check("hold_accepts", accepts, 2);
        check("hold_first_acc", first_acc, 0);
        check("hold_second_acc", second_acc, 3);
        check("hold_handshakes", hs, 2);
        check("hold_data_oks", dok, 2);
        do_reset();

        // Watchdog fires after eight BUSY cycles with no response.
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_2000_0000;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
        #1;
        check("to_accept", dresp.addr_ok, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            dreq.valid = 1'b0;
            #1;
            check("to_busy_valid", creq.valid, 1'b1);
            check("to_busy_no_ok", dresp.data_ok, 1'b0);
        end
        @(negedge clk);
        #1;
        check("to_data_ok", dresp.data_ok, 1'b1);
        check("to_data", dresp.data, 64'hDEAD_BEEF_DEAD_BEEF);
        check("to_err", err_timeout, 1'b1);
        check("to_creq_drop", creq.valid, 1'b0);
        @(negedge clk);
        #1;
        check("to_err_sticky", err_timeout, 1'b1);
        check("to_ok_gone", dresp.data_ok, 1'b0);
        do_reset();

        // Completion on the last allowed cycle beats the watchdog.
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_2000_0008;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
        #1;
        check("race_accept", dresp.addr_ok, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            dreq.valid = 1'b0;
            #1;
            check("race_busy_valid", creq.valid, 1'b1);
        end
        @(negedge clk);
        cresp.ready = 1'b1;
        cresp.last  = 1'b1;
        cresp.data  = 64'h600D_600D_600D_600D;
        #1;
        check("race_busy8_valid", creq.valid, 1'b1);
        @(negedge clk);
        cresp = '0;
        #1;
        check("race_data_ok", dresp.data_ok, 1'b1);
        check("race_data", dresp.data, 64'h600D_600D_600D_600D);
        check("race_no_err", err_timeout, 1'b0);
        do_reset();

        // Reset while BUSY aborts the transaction and clears the sticky flags.
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_8000_0001;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
        #1;
        check("rb_accept", dresp.addr_ok, 1'b1);
        @(negedge clk);
        dreq.valid = 1'b0;
        #1;
        check("rb_busy_valid", creq.valid, 1'b1);
        check("rb_mis_set", err_misaligned, 1'b1);
        reset       = 1'b1;
        cresp.ready = 1'b1;
        cresp.last  = 1'b1;
        cresp.data  = 64'h99;
        @(negedge clk);
        reset = 1'b0;
        cresp = '0;
        #1;
        check("rb_creq_valid", creq.valid, 1'b0);
        check("rb_no_data_ok", dresp.data_ok, 1'b0);
        check("rb_mis_clear", err_misaligned, 1'b0);
        check("rb_to_clear", err_timeout, 1'b0);
        run_txn(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
